// File: rtl/tnn_pkg.sv
// Shared types for the ternary (TNN) activation path: trit coding and
// the decompressor state encoding.
package tnn_pkg;

    typedef logic signed [1:0] trit_t;

    localparam int TRITS_PER_BYTE = 5;

    localparam trit_t TRIT_NEG  = 2'b11;
    localparam trit_t TRIT_ZERO = 2'b00;
    localparam trit_t TRIT_POS  = 2'b01;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } tdc_state_e;

endpackage

// File: rtl/ternary_decoder.sv
// Unpacks one base-3 encoded byte into five trits. The encoder stores
// byte = sum((t_i + 1) * 3^i), trit 0 being the least significant digit.
// Bytes above 242 never come from the encoder; they still decode to legal
// trits (digit taken mod 3) so 2'b10 can never leak downstream.
module ternary_decoder
    import tnn_pkg::*;
(
    input  logic [7:0] byte_i,
    output trit_t      trits_o [TRITS_PER_BYTE]
);

    logic [7:0] rem;

    // Peel base-3 digits off the low end, mapping digit 0/1/2 to -1/0/+1.
    always_comb begin
        rem = byte_i;
        for (int i = 0; i < TRITS_PER_BYTE; i++) begin
            case (rem % 8'd3)
                8'd0:    trits_o[i] = TRIT_NEG;
                8'd1:    trits_o[i] = TRIT_ZERO;
                default: trits_o[i] = TRIT_POS;
            endcase
            rem = rem / 8'd3;
        end
    end

endmodule

// File: rtl/ternary_decompress.sv
// Ternary activation decompressor: accepts packed words of base-3 bytes,
// buffers one decoded word and streams it out in OUT_LANES-wide beats.
//
//   state | meaning
//   EMPTY | no word buffered, input always ready (unless clearing)
//   DRAIN | buffered word being emitted, beat_q = beat on the output
//
// in_ready_o rises combinationally on the final accepted beat so a new
// word can be loaded in the same cycle without an output bubble.
module ternary_decompress
    import tnn_pkg::*;
#(
    parameter  int IN_BYTES  = 4,
    parameter  int OUT_LANES = 4,
    localparam int TRITS     = TRITS_PER_BYTE * IN_BYTES,
    localparam int CNT_W     = $clog2(TRITS + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic [8*IN_BYTES-1:0]       in_data_i,
    input  logic [CNT_W-1:0]            in_ntrits_i,
    input  logic                        in_last_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic [OUT_LANES-1:0][1:0]   out_trits_o,
    output logic [OUT_LANES-1:0]        out_mask_o,
    output logic                        out_last_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i
);

    localparam int MAX_BEATS = (TRITS + OUT_LANES - 1) / OUT_LANES;
    localparam int BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] TRITS_C = CNT_W'(TRITS);

    // Index of the final beat for a word of n trits (n > 0).
    function automatic int last_beat(input logic [CNT_W-1:0] n);
        return (int'(n) + OUT_LANES - 1) / OUT_LANES - 1;
    endfunction

    logic [TRITS-1:0][1:0] dec_trits;

    for (genvar b = 0; b < IN_BYTES; b++) begin : g_dec
        trit_t byte_trits [TRITS_PER_BYTE];

        ternary_decoder u_dec (
            .byte_i  (in_data_i[8*b +: 8]),
            .trits_o (byte_trits)
        );

        for (genvar i = 0; i < TRITS_PER_BYTE; i++) begin : g_trit
            assign dec_trits[TRITS_PER_BYTE*b + i] = byte_trits[i];
        end
    end

    tdc_state_e                state_q,      state_d;
    logic [BEAT_W-1:0]         beat_q,       beat_d;
    logic [TRITS-1:0][1:0]     trits_q,      trits_d;
    logic [CNT_W-1:0]          ntrits_q,     ntrits_d;
    logic                      last_q,       last_d;
    logic                      out_valid_q,  out_valid_d;
    logic [OUT_LANES-1:0][1:0] out_trits_q,  out_trits_d;
    logic [OUT_LANES-1:0]      out_mask_q,   out_mask_d;
    logic                      out_last_q,   out_last_d;

    logic [CNT_W-1:0] ntrits_in;
    logic             final_beat;
    logic             accept;

    assign ntrits_in  = (in_ntrits_i > TRITS_C) ? TRITS_C : in_ntrits_i;
    assign final_beat = (state_q == DRAIN) && (int'(beat_q) == last_beat(ntrits_q));
    assign in_ready_o = !clear_i && ((state_q == EMPTY) || (final_beat && out_ready_i));
    assign accept     = in_valid_i && in_ready_o;

    // Next buffered word / beat position, then the beat that will be on the
    // output next cycle, so every output comes straight from a flop.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        trits_d  = trits_q;
        ntrits_d = ntrits_q;
        last_d   = last_q;

        if (clear_i) begin
            state_d = EMPTY;
            beat_d  = '0;
        end else if (accept) begin
            beat_d = '0;
            if (ntrits_in != '0) begin
                state_d  = DRAIN;
                trits_d  = dec_trits;
                ntrits_d = ntrits_in;
                last_d   = in_last_i;
            end else begin
                state_d = EMPTY;
            end
        end else if ((state_q == DRAIN) && out_ready_i) begin
            if (final_beat) begin
                state_d = EMPTY;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end

        out_valid_d = 1'b0;
        out_trits_d = '0;
        out_mask_d  = '0;
        out_last_d  = 1'b0;
        if (state_d == DRAIN) begin
            out_valid_d = 1'b1;
            out_last_d  = last_d && (int'(beat_d) == last_beat(ntrits_d));
            for (int l = 0; l < OUT_LANES; l++) begin
                if (int'(beat_d) * OUT_LANES + l < int'(ntrits_d)) begin
                    out_mask_d[l]  = 1'b1;
                    out_trits_d[l] = trits_d[int'(beat_d) * OUT_LANES + l];
                end
            end
        end
    end

    // State, buffered word and registered output beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            beat_q      <= '0;
            trits_q     <= '0;
            ntrits_q    <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_trits_q <= '0;
            out_mask_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            trits_q     <= trits_d;
            ntrits_q    <= ntrits_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_trits_q <= out_trits_d;
            out_mask_q  <= out_mask_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_trits_o = out_trits_q;
    assign out_mask_o  = out_mask_q;
    assign out_last_o  = out_last_q;

    // An out-of-range trit count is clamped above; flag it in simulation.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     in_valid_i |-> (in_ntrits_i <= TRITS_C))
        else $error("ternary_decompress: in_ntrits_i %0d exceeds %0d", in_ntrits_i, TRITS);

endmodule

// File: doc/ternary_decompress.md
Name: ternary_decompress

Overview:
- Downstream consumer of the threshold/compress stage's packed ternary activations.
- Takes 32-bit words of 4 packed bytes, each holding 5 trits.
- Unpacks each word and streams the trits to the TNN dot-product datapath in OUT_LANES-wide beats.
- Uses valid/ready handshakes on both sides; supports partial final words and zero-bubble back-to-back operation.

Parameters:
- IN_BYTES, 4: encoded bytes per input word; TRITS = 5*IN_BYTES.
- OUT_LANES, 4: trits per output beat; 1 <= OUT_LANES <= TRITS.
- CNT_W, $clog2(TRITS+1): width of trit counts (localparam).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous flush; drops the buffered word
- in_data_i  in  8*IN_BYTES  packed word; byte b (bits 8b+7:8b) holds trits 5b..5b+4
- in_ntrits_i  in  CNT_W  number of valid trits in the word, 0..TRITS
- in_last_i  in  1  word ends the current activation tile
- in_valid_i  in  1  input handshake valid
- in_ready_o  out  1  input handshake ready
- out_trits_o  out  OUT_LANES x 2  signed trits, lane 0 = lowest trit index
- out_mask_o  out  OUT_LANES  per-lane valid mask
- out_last_o  out  1  final beat of a word flagged in_last_i
- out_valid_o  out  1  output handshake valid
- out_ready_i  in  1  output handshake ready

Behaviour:
- Reset is asynchronous on rst_ni.
  - out_valid_o=0, out_trits_o=0, out_mask_o=0, out_last_o=0, in_ready_o=1.
  - State EMPTY, beat_q=0.
- Trit coding: 2'b11=-1, 2'b00=0, 2'b01=+1. 2'b10 is never emitted.
- Decode is combinational on in_data_i via ternary_decoder instances. Decoded trits (2*TRITS bits), ntrits and last are registered on accept.
- Accept occurs when in_valid_i & in_ready_o.
- Latency: a word accepted at edge k presents its first beat (out_valid_o=1) from cycle k+1. Output signals are register-driven.
- Beat count: BEATS = ceil(ntrits/OUT_LANES).
  - Beat n carries trits n*OUT_LANES .. n*OUT_LANES+OUT_LANES-1.
  - Lanes with index >= ntrits output 0 with mask bit 0.
- State machine:
  - EMPTY: in_ready_o=1, out_valid_o=0.
    - Accept with ntrits>0 -> DRAIN, beat_q=0.
    - Accept with ntrits==0 -> word dropped, stay EMPTY, no beat, last flag discarded.
  - DRAIN: out_valid_o=1. On out_ready_i, beat_q increments.
    - Final beat (beat_q==BEATS-1) & out_ready_i: in_ready_o=1 in the same cycle (combinational pass-through).
    - If a new word is accepted in that same cycle -> reload, beat_q=0, stay DRAIN (zero bubble). Otherwise -> EMPTY.
    - Non-final beat: in_ready_o=0.
- out_last_o=1 only on the final beat of a word stored with last=1.
- Backpressure: while out_valid_o & !out_ready_i, out_trits_o, out_mask_o, out_last_o and beat_q hold stable.
- clear_i has priority over every handshake.
  - Next state EMPTY, out_valid_o=0, beat_q=0, outputs zeroed.
  - An input presented in the same cycle is not accepted: in_ready_o=0 while clear_i=1.
- Illegal in_ntrits_i > TRITS: clamp to TRITS and fire a simulation assertion.
- Beat counter width is $clog2(ceil(TRITS/OUT_LANES)). There is no wrap beyond BEATS-1.

Decomposition:
- tnn_pkg contains:
  - typedef trit_t (logic signed [1:0])
  - TRITS_PER_BYTE=5
  - TRIT_NEG/TRIT_ZERO/TRIT_POS
  - state enum tdc_state_e {EMPTY, DRAIN}
- Sub-module ternary_decoder: combinational 8-bit -> 5 x trit_t.
  - Exact inverse of ternary_encoder.
  - One instance per byte (generate loop).

Test Plan:
- Reset with rst_ni low mid-DRAIN -> outputs zero, in_ready_o=1 immediately; after release, first accept behaves normally.
- Full word: trits 0..19 = (+1,0,-1) repeating, encoded via the ternary_encoder model; ntrits=20, out_ready_i=1.
  - Expect 5 beats in cycles k+1..k+5, lanes in order, mask 4'hF.
  - in_ready_o=0 until the 5th-beat cycle.
- Back-to-back: two words, in_valid_i held high -> 10 consecutive beats with no out_valid_o gap; second word's first beat at cycle k+6.
- Partial last: ntrits=7, last=1, trits (-1,-1,0,+1,+1,0,-1).
  - Beat 0 = (-1,-1,0,+1), mask 4'hF, out_last_o=0.
  - Beat 1 = (+1,0,-1,0), mask 4'b0111, out_last_o=1.
- Backpressure: out_ready_i low 3 cycles on beat 2 -> beat 2 payload stable for 4 cycles, no beat skipped, totals unchanged.
- ntrits=0 word, then clear_i asserted during DRAIN of the next word.
  - The ntrits=0 word produces no beat.
  - On clear_i: out_valid_o=0 next cycle, in_ready_o=0 during the clear cycle, 1 after.
